// File: rtl/seven_segment_decoder.sv
// Snoops the active-low multiplexed seven-segment bus and rebuilds
// the packed BCD word and dot mask, one frame per complete scan.
module seven_segment_decoder #(
  parameter logic [3:0] BLANK_CODE = 4'hF,
  parameter logic [3:0] ERR_CODE   = 4'hE
) (
  input  logic        clk_8KHz,
  input  logic        rst,
  input  logic [7:0]  pos,
  input  logic [7:0]  segments,
  output logic [31:0] digit,
  output logic [7:0]  en_dot,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        frame_changed
);

  logic [7:0] r_pos_q;
  logic [7:0] r_seg_q;
  logic [3:0] r_buf_digit [7];
  logic [6:0] r_buf_dot;
  logic [6:0] r_seen;
  logic       r_err_acc;

  logic [7:0]  w_npos;
  logic        w_idle;
  logic        w_onehot;
  logic [2:0]  w_slot;
  logic [3:0]  w_nib;
  logic        w_dot;
  logic        w_seg_err;
  logic        w_close;
  logic        w_full;
  logic [31:0] w_new_digit;
  logic [7:0]  w_new_dot;

  always_comb begin
    w_npos   = ~r_pos_q;
    w_idle   = (r_pos_q == 8'hFF);
    w_onehot = (w_npos != 8'd0) &&
               ((w_npos & (w_npos - 8'd1)) == 8'd0);
    w_slot = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_npos[i]) w_slot = 3'(i);
    end
    w_dot     = ~r_seg_q[0];
    w_seg_err = 1'b0;
    w_nib     = ERR_CODE;
    case (r_seg_q[7:1])
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b1111111: w_nib = BLANK_CODE;
      default: begin
        w_nib     = ERR_CODE;
        w_seg_err = 1'b1;
      end
    endcase
    // slot 7 is never buffered; it is merged straight into the frame
    w_new_digit = 32'd0;
    for (int i = 0; i < 7; i++) begin
      w_new_digit[4*i +: 4] = r_buf_digit[i];
    end
    w_new_digit[31:28] = w_nib;
    w_new_dot = {w_dot, r_buf_dot};
    w_close   = w_onehot && (w_slot == 3'd7);
    w_full    = &r_seen;
  end

  always_ff @(posedge clk_8KHz) begin
    if (rst) begin
      r_pos_q       <= 8'hFF;
      r_seg_q       <= 8'hFF;
      r_buf_dot     <= 7'd0;
      r_seen        <= 7'd0;
      r_err_acc     <= 1'b0;
      digit         <= 32'hFFFF_FFFF;
      en_dot        <= 8'h00;
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      frame_changed <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        r_buf_digit[i] <= BLANK_CODE;
      end
    end else begin
      r_pos_q       <= pos;
      r_seg_q       <= segments;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      if (!w_idle && !w_onehot) begin
        r_err_acc <= 1'b1;
      end else if (w_close) begin
        if (w_full) begin
          digit         <= w_new_digit;
          en_dot        <= w_new_dot;
          frame_err     <= r_err_acc | w_seg_err;
          frame_valid   <= 1'b1;
          frame_changed <= ({w_new_digit, w_new_dot} != {digit, en_dot});
        end
        r_seen    <= 7'd0;
        r_err_acc <= 1'b0;
      end else if (w_onehot) begin
        r_buf_digit[w_slot] <= w_nib;
        r_buf_dot[w_slot]   <= w_dot;
        r_seen[w_slot]      <= 1'b1;
        if (w_seg_err) r_err_acc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench: a frame model pushes expected frames as the bus
// is driven; a negedge monitor pops and compares on frame_valid.
module tb_seven_segment_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pos = 8'hFF;
  logic [7:0]  segments = 8'hFF;
  logic [31:0] digit;
  logic [7:0]  en_dot;
  logic        frame_valid;
  logic        frame_err;
  logic        frame_changed;

  seven_segment_decoder dut (
    .clk_8KHz      (clk),
    .rst           (rst),
    .pos           (pos),
    .segments      (segments),
    .digit         (digit),
    .en_dot        (en_dot),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err),
    .frame_changed (frame_changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  dt;
    logic        err;
    logic        chg;
    int          at;
  } frame_t;

  frame_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] m_d;
  logic [7:0]  m_dt;
  logic [7:0]  m_seen;
  logic        m_err;
  logic [31:0] m_prev_d;
  logic [7:0]  m_prev_dt;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_d       = 32'hFFFF_FFFF;
    m_dt      = 8'h00;
    m_seen    = 8'h00;
    m_err     = 1'b0;
    m_prev_d  = 32'hFFFF_FFFF;
    m_prev_dt = 8'h00;
  endtask

  task automatic put(input logic [7:0] p, input logic [7:0] s,
                     input logic [3:0] enib, input logic edot,
                     input logic eerr);
    int zeros;
    int idx;
    frame_t f;
    @(negedge clk);
    pos = p;
    segments = s;
    zeros = 0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (!p[i]) begin
        zeros++;
        idx = i;
      end
    end
    if (zeros == 0) return;
    if (zeros > 1) begin
      m_err = 1'b1;
      return;
    end
    if (idx == 7) begin
      if (m_seen[6:0] == 7'h7F) begin
        f.d   = {enib, m_d[27:0]};
        f.dt  = {edot, m_dt[6:0]};
        f.err = m_err | eerr;
        f.chg = ({f.d, f.dt} != {m_prev_d, m_prev_dt});
        f.at  = cyc + 2;
        sb.push_back(f);
        m_prev_d  = f.d;
        m_prev_dt = f.dt;
      end
      m_seen = 8'h00;
      m_err  = 1'b0;
    end else begin
      m_d[4*idx +: 4] = enib;
      m_dt[idx]       = edot;
      m_seen[idx]     = 1'b1;
      m_err           = m_err | eerr;
    end
  endtask

  task automatic slot(input int i, input logic [31:0] d,
                      input logic [7:0] dt);
    put(~(8'd1 << i), {enc(d[4*i +: 4]), ~dt[i]}, d[4*i +: 4],
        dt[i], 1'b0);
  endtask

  task automatic scan(input logic [31:0] d, input logic [7:0] dt,
                      input int first, input int bad_seg,
                      input int badpos_after);
    for (int i = first; i < 8; i++) begin
      if (i == bad_seg)
        put(~(8'd1 << i), 8'b01010101, 4'hE, 1'b0, 1'b1);
      else
        slot(i, d, dt);
      if (i == badpos_after)
        put(8'h7C, 8'hFF, 4'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(8'hFF, 8'hFF, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_digit"}, 64'(digit), 64'hFFFF_FFFF);
    chk({tag, "_dot"}, 64'(en_dot), 64'h0);
    chk({tag, "_fv"}, 64'(frame_valid), 64'h0);
    chk({tag, "_ferr"}, 64'(frame_err), 64'h0);
    chk({tag, "_fchg"}, 64'(frame_changed), 64'h0);
  endtask

  task automatic do_reset();
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    pos = 8'hFF;
    segments = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("rst");
  endtask

  always @(negedge clk) begin
    frame_t e;
    if (!rst && frame_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_fv", 64'(frame_valid), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("fv_cycle", 64'(cyc), 64'(e.at));
        chk("digit", 64'(digit), 64'(e.d));
        chk("en_dot", 64'(en_dot), 64'(e.dt));
        chk("frame_err", 64'(frame_err), 64'(e.err));
        chk("frame_chg", 64'(frame_changed), 64'(e.chg));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("init");

    scan(32'h12345678, 8'h00, 0, -1, -1);
    scan(32'h12345678, 8'h00, 0, -1, -1);
    scan(32'hFFFF0009, 8'h81, 0, -1, -1);
    scan(32'h98765432, 8'h10, 0, 2, -1);
    scan(32'h98765432, 8'h10, 0, -1, -1);
    idle(3);

    do_reset();
    scan(32'h12345678, 8'h00, 4, -1, -1);
    scan(32'h12345678, 8'h00, 0, -1, -1);
    scan(32'h01020304, 8'h42, 0, -1, 3);
    idle(2);

    for (int i = 0; i < 5; i++) slot(i, 32'h55555555, 8'h00);
    do_reset();
    scan(32'h87654321, 8'h00, 3, -1, -1);
    scan(32'h87654321, 8'h00, 0, -1, -1);
    scan(32'h87654321, 8'h00, 0, -1, -1);
    idle(4);

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
